// File: rtl/gen_ppbuff_drain.sv
// gen_ppbuff_drain
// Drains a ping-pong buffer entry by entry. It snapshots the valid vector and
// streams the valid entries out in ascending index order. It then pulses pop
// to retire the buffer and waits one settle cycle before it looks again.

module gen_ppbuff_drain #(
  parameter int DW = 100,
  parameter int DP = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  flush,
  input  logic [DW*DP-1:0]      buf_info_i,
  input  logic [DP-1:0]         buf_valid_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_info,
  output logic [$clog2(DP)-1:0] out_index,
  output logic                  pop_o,
  output logic                  busy_o
);

  localparam int IW = $clog2(DP);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    POP,
    SETTLE
  } state_t;

  state_t          state;
  logic [DP-1:0]   mask;
  logic [IW-1:0]   low_idx;
  logic [DW-1:0]   low_info;
  logic            can_advance;

  // The lowest set bit of the remaining mask picks the next entry. Scanning
  // downward lets the lowest index win, and it selects the matching payload slice.
  always_comb begin
    low_idx  = '0;
    low_info = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx  = IW'(i);
        low_info = buf_info_i[i*DW +: DW];
      end
    end
  end

  // The output register can take a new entry when it is empty or being accepted.
  always_comb begin
    can_advance = ~out_valid | out_ready;
  end

  // Drain state machine with every output registered.
  // flush outranks every transition. A beat that is held keeps info, index and mask frozen.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      mask      <= '0;
      out_valid <= 1'b0;
      out_info  <= '0;
      out_index <= '0;
      pop_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      mask      <= '0;
      out_valid <= 1'b0;
      pop_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pop_o <= 1'b0;
          if (|buf_valid_i) begin
            mask   <= buf_valid_i;
            state  <= DRAIN;
            busy_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (can_advance) begin
            if (mask != '0) begin
              out_info        <= low_info;
              out_index       <= low_idx;
              out_valid       <= 1'b1;
              mask[low_idx]   <= 1'b0;
            end else begin
              out_valid <= 1'b0;
              pop_o     <= 1'b1;
              state     <= POP;
            end
          end
        end
        POP: begin
          pop_o <= 1'b0;
          state <= SETTLE;
        end
        SETTLE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mask      <= '0;
          out_valid <= 1'b0;
          pop_o     <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gen_ppbuff_drain.sv
// tb_gen_ppbuff_drain
// Scoreboard bench for the buffer drain.
// Stimulus queues the beats the consumer should accept.
// A negedge monitor pops and compares each accepted beat and tallies pop pulses.

module tb_gen_ppbuff_drain;

  localparam int DW = 100;
  localparam int DP = 8;
  localparam int IW = 3;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              flush = 1'b0;
  logic [DW*DP-1:0]  buf_info_i;
  logic [DP-1:0]     buf_valid_i = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_info;
  logic [IW-1:0]     out_index;
  logic              pop_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  int pops_seen = 0;
  int pops_expected = 0;
  int drain_cycles;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] info;
  } beat_t;

  beat_t          exp_q[$];
  beat_t          mon_beat;
  logic [DW-1:0]  entry_info [DP];

  gen_ppbuff_drain #(.DW(DW), .DP(DP)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .flush       (flush),
    .buf_info_i  (buf_info_i),
    .buf_valid_i (buf_valid_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_info    (out_info),
    .out_index   (out_index),
    .pop_o       (pop_o),
    .busy_o      (busy_o)
  );

  // Free-running clock with a 10-unit period.
  always #5 CLK = ~CLK;

  // Each entry gets a distinct payload so that a wrong slice shows up at once.
  initial begin
    for (int k = 0; k < DP; k++) begin
      entry_info[k] = {36'hA5A5A5A5A, 32'hC0DE0000 | 32'(k), 32'(k) * 32'h01010101};
      buf_info_i[k*DW +: DW] = entry_info[k];
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the valid vector and ready. Queue the first n_expect set bits as expected beats.
  task automatic applyStimulus(input logic [DP-1:0] valid, input logic ready, input int n_expect);
    int pushed;
    pushed = 0;
    buf_valid_i = valid;
    out_ready   = ready;
    for (int k = 0; k < DP; k++) begin
      if (valid[k] && pushed < n_expect) begin
        exp_q.push_back(beat_t'{idx: IW'(k), info: entry_info[k]});
        pushed++;
      end
    end
  endtask

  // Bounded wait for busy_o to drop. A timeout counts as a failed check.
  task automatic waitIdle(input string name, output int cycles);
    int n;
    n = 0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    cycles = n;
    checkOutput({name, "_idle_timeout"}, busy_o, 0);
  endtask

  // The monitor compares each handshake with the head of the queue and counts pop cycles.
  always @(negedge CLK) begin
    if (RSTn && pop_o) pops_seen++;
    if (RSTn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat actual=idx %0d required=no beat", out_index);
      end else begin
        mon_beat = exp_q.pop_front();
        checkOutput("beat_index", out_index, mon_beat.idx);
        checkOutput("beat_info", out_info, mon_beat.info);
      end
    end
  end

  // Safety net so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence T1..T6.
  initial begin
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_pop", pop_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_index", out_index, 0);
    checkOutput("reset_info", out_info, 0);
    tick();
    tick();
    RSTn = 1'b1;
    tick();
    checkOutput("idle_no_busy", busy_o, 0);

    // T1: two sparse entries with ready always high.
    $display("[TB] T1 sparse drain");
    applyStimulus(8'h05, 1'b1, 2);
    tick();
    buf_valid_i = '0;
    checkOutput("t1_busy_snapshot", busy_o, 1);
    checkOutput("t1_no_beat_yet", out_valid, 0);
    tick();
    checkOutput("t1_beat0_valid", out_valid, 1);
    checkOutput("t1_beat0_index", out_index, 0);
    tick();
    checkOutput("t1_beat1_index", out_index, 2);
    checkOutput("t1_no_pop_yet", pop_o, 0);
    tick();
    pops_expected++;
    checkOutput("t1_pop_high", pop_o, 1);
    checkOutput("t1_valid_low_at_pop", out_valid, 0);
    tick();
    checkOutput("t1_pop_one_cycle", pop_o, 0);
    checkOutput("t1_busy_settle", busy_o, 1);
    tick();
    checkOutput("t1_busy_dropped", busy_o, 0);

    // T2: a full buffer drains back to back. From the snapshot that takes 8 beats, a pop cycle and a settle cycle.
    $display("[TB] T2 full drain");
    applyStimulus(8'hFF, 1'b1, 8);
    tick();
    buf_valid_i = '0;
    pops_expected++;
    waitIdle("t2", drain_cycles);
    checkOutput("t2_drain_cycles", drain_cycles, 11);
    checkOutput("t2_all_beats", exp_q.size(), 0);

    // T3: back-pressure on the first beat.
    $display("[TB] T3 backpressure");
    applyStimulus(8'h82, 1'b0, 2);
    tick();
    buf_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("t3_hold_valid", out_valid, 1);
      checkOutput("t3_hold_index", out_index, 1);
      checkOutput("t3_hold_info", out_info, entry_info[1]);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("t3_second_index", out_index, 7);
    tick();
    pops_expected++;
    checkOutput("t3_pop", pop_o, 1);
    waitIdle("t3", drain_cycles);

    // T4: flush while the second of four beats waits.
    $display("[TB] T4 flush");
    applyStimulus(8'h0F, 1'b1, 1);
    tick();
    buf_valid_i = '0;
    tick();
    tick();
    checkOutput("t4_pending_index", out_index, 1);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("t4_flush_valid", out_valid, 0);
    checkOutput("t4_flush_busy", busy_o, 0);
    checkOutput("t4_flush_pop", pop_o, 0);
    tick();
    tick();
    tick();
    checkOutput("t4_stays_idle", busy_o, 0);
    checkOutput("t4_no_pop", pops_seen, pops_expected);
    checkOutput("t4_queue_empty", exp_q.size(), 0);

    // T5: the valid vector grows after the snapshot.
    $display("[TB] T5 late valid");
    applyStimulus(8'h01, 1'b1, 1);
    tick();
    buf_valid_i = 8'h03;
    tick();
    checkOutput("t5_beat_index", out_index, 0);
    tick();
    pops_expected++;
    checkOutput("t5_pop", pop_o, 1);
    checkOutput("t5_no_second_beat", out_valid, 0);
    tick();
    checkOutput("t5_settle_busy", busy_o, 1);
    checkOutput("t5_settle_no_beat", out_valid, 0);
    tick();
    checkOutput("t5_idle_after_settle", busy_o, 0);
    applyStimulus(8'h03, 1'b1, 2);
    tick();
    buf_valid_i = '0;
    checkOutput("t5_redrain_busy", busy_o, 1);
    pops_expected++;
    waitIdle("t5", drain_cycles);

    // T6: asynchronous reset in the middle of a drain.
    $display("[TB] T6 async reset");
    applyStimulus(8'hFF, 1'b1, 1);
    tick();
    buf_valid_i = '0;
    tick();
    tick();
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_info", out_info, 0);
    checkOutput("t6_rst_index", out_index, 0);
    checkOutput("t6_rst_pop", pop_o, 0);
    checkOutput("t6_rst_busy", busy_o, 0);
    tick();
    tick();
    RSTn = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    checkOutput("t6_idle_busy", busy_o, 0);
    checkOutput("t6_idle_valid", out_valid, 0);
    applyStimulus(8'h01, 1'b1, 1);
    tick();
    buf_valid_i = '0;
    pops_expected++;
    waitIdle("t6", drain_cycles);

    tick();
    tick();
    checkOutput("final_queue_empty", exp_q.size(), 0);
    checkOutput("final_pop_count", pops_seen, pops_expected);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
